// File: rtl/inst_loader_pkg.sv
// Shared types and widths for the instruction-memory boot loader.
package inst_loader_pkg;

    localparam int INST_ADDR_W   = 11;
    localparam int INST_W        = 9;
    localparam int STREAM_BYTE_W = 8;
    localparam int LOAD_LEN_W    = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_INST_HI,
        S_INST_LO,
        S_DONE,
        S_ERR
    } loader_state_t;

endpackage

// File: rtl/inst_loader.sv
// Boot loader: assembles instructions from a byte stream and writes them into the instruction RAM.
//
// state     | meaning
// ----------+--------------------------------------------------
// S_IDLE    | waiting for start, stream not accepted
// S_LEN_HI  | expecting length[15:8]
// S_LEN_LO  | expecting length[7:0], length is validated here
// S_INST_HI | expecting instruction high byte (reserved bits checked)
// S_INST_LO | expecting instruction low byte, issues the RAM write
// S_DONE    | image written, start reloads
// S_ERR     | malformed stream, only Reset leaves
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W,
    parameter int INST_W = inst_loader_pkg::INST_W
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     start,
    input  logic [STREAM_BYTE_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [INST_W-1:0]        mem_wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [ADDR_W:0]          count
);

    localparam logic [LOAD_LEN_W:0] MAX_LEN = (LOAD_LEN_W+1)'(2**ADDR_W);

    loader_state_t         state_q, state_d;
    logic [LOAD_LEN_W-1:0] len_q, len_d;
    logic [INST_W-9:0]     hi_q, hi_d;
    logic [ADDR_W:0]       count_q, count_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [INST_W-1:0]     mem_wdata_q, mem_wdata_d;

    logic                  accept;
    logic [LOAD_LEN_W-1:0] new_len;
    logic [LOAD_LEN_W-1:0] written_next;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            hi_q        <= '0;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            hi_q        <= hi_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_INST_HI) || (state_q == S_INST_LO);
    assign accept       = in_valid && in_ready;
    assign new_len      = {len_q[LOAD_LEN_W-1:8], in_data};
    assign written_next = LOAD_LEN_W'(count_q) + LOAD_LEN_W'(1);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        hi_d        = hi_q;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_LEN_HI;
                    count_d    = '0;
                    mem_addr_d = '0;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d[LOAD_LEN_W-1:8] = in_data;
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d = new_len;
                    if (new_len == '0)
                        state_d = S_DONE;
                    else if ({1'b0, new_len} > MAX_LEN)
                        state_d = S_ERR;
                    else
                        state_d = S_INST_HI;
                end
            end
            S_INST_HI: begin
                if (accept) begin
                    // Bits above the instruction's top field are reserved and must be zero.
                    if ((in_data >> (INST_W-8)) != '0) begin
                        state_d = S_ERR;
                    end else begin
                        hi_d    = in_data[INST_W-9:0];
                        state_d = S_INST_LO;
                    end
                end
            end
            S_INST_LO: begin
                if (accept) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = count_q[ADDR_W-1:0];
                    mem_wdata_d = {hi_q, in_data};
                    if (LOAD_LEN_W'(count_q) < len_q)
                        count_d = count_q + (ADDR_W+1)'(1);
                    state_d = (written_next >= len_q) ? S_DONE : S_INST_HI;
                end
            end
            S_ERR: ;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = in_ready;
    // Holding done off while the final write is on the port keeps done behind the last commit.
    assign done      = (state_q == S_DONE) && !mem_we_q;
    assign err       = (state_q == S_ERR);
    assign count     = count_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: stream-level model of expected writes plus directed timing checks.
module tb_inst_loader;

    typedef logic [7:0] bq_t[$];

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready, mem_we, busy, done, err;
    logic [10:0] mem_addr;
    logic [8:0]  mem_wdata;
    logic [11:0] count;

    int n_assert = 0;
    int n_fail   = 0;
    logic [19:0] exp_wr[$];
    logic [10:0] last_addr = '0;
    logic        prev_we = 1'b0;

    inst_loader dut (
        .Clk(Clk), .Reset(Reset), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .done(done), .err(err), .count(count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream-level model: outcome 0=done, 1=err, 2=incomplete; expected writes pushed to exp_wr.
    task automatic model(input bq_t b, output int outcome, output int exp_cnt);
        int n;
        outcome = 2;
        exp_cnt = 0;
        if (b.size() < 2) return;
        n = (int'(b[0]) << 8) | int'(b[1]);
        if (n == 0) begin outcome = 0; return; end
        if (n > 2048) begin outcome = 1; return; end
        for (int i = 0; i < n; i++) begin
            if (b.size() < 3 + 2*i) return;
            if ((b[2+2*i] >> 1) != 0) begin outcome = 1; return; end
            if (b.size() < 4 + 2*i) return;
            exp_wr.push_back({11'(i), b[2+2*i][0], b[3+2*i]});
            exp_cnt = i + 1;
        end
        outcome = 0;
    endtask

    task automatic send_bytes(input bq_t b, input bit stall, input int limit, output int nacc);
        int i = 0;
        int cyc = 0;
        while (i < b.size() && cyc < limit) begin
            @(negedge Clk);
            in_data  = b[i];
            in_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (in_valid && in_ready) i++;
            cyc++;
        end
        @(posedge Clk);
        #1 in_valid = 1'b0;
        nacc = i;
    endtask

    task automatic do_start();
        @(negedge Clk) start = 1'b1;
        @(negedge Clk) start = 1'b0;
    endtask

    task automatic check_end(input string tag, input int outcome, input int cnt);
        @(negedge Clk);
        if (outcome == 1) begin
            chk({tag, "_err"}, err, 1);
            chk({tag, "_ready_low"}, in_ready, 0);
            chk({tag, "_no_done"}, done, 0);
        end else if (cnt == 0) begin
            chk({tag, "_done_next"}, done, 1);
            chk({tag, "_count0"}, count, 0);
            chk({tag, "_no_err"}, err, 0);
        end else begin
            chk({tag, "_done_not_yet"}, done, 0);
            @(negedge Clk);
            chk({tag, "_done"}, done, 1);
            chk({tag, "_count"}, count, cnt);
            chk({tag, "_no_err"}, err, 0);
        end
        chk({tag, "_writes_left"}, exp_wr.size(), 0);
    endtask

    task automatic run_load(input string tag, input bq_t b, input bit stall);
        int oc, cnt, nacc;
        model(b, oc, cnt);
        send_bytes(b, stall, 20000, nacc);
        chk({tag, "_accepted"}, nacc, b.size());
        check_end(tag, oc, cnt);
    endtask

    always @(negedge Clk) begin
        if (mem_we) begin
            if (exp_wr.size() == 0) begin
                chk("extra_write", 1, 0);
            end else begin
                logic [19:0] e;
                e = exp_wr.pop_front();
                chk("wr_addr", mem_addr, e[19:9]);
                chk("wr_data", mem_wdata, e[8:0]);
            end
            last_addr = mem_addr;
        end
        if (prev_we && mem_we) chk("we_single_pulse", 1, 0);
        prev_we = mem_we;
        chk("busy_eq_ready", busy, in_ready);
    end

    initial begin : main
        bq_t nom, b, first4;
        int oc, cnt, nacc;
        nom = '{8'h00, 8'h03, 8'h01, 8'h31, 8'h01, 8'h02, 8'h00, 8'h33};

        repeat (3) @(negedge Clk);
        chk("rst_ready", in_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_count", count, 0);
        Reset = 1'b0;
        @(negedge Clk);
        chk("idle_ready", in_ready, 0);

        model(nom, oc, cnt);
        chk("pin_outcome", oc, 0);
        chk("pin_count", cnt, 3);
        chk("pin_wr0", exp_wr[0], {11'd0, 9'h131});
        chk("pin_wr1", exp_wr[1], {11'd1, 9'h102});
        chk("pin_wr2", exp_wr[2], {11'd2, 9'h033});
        exp_wr.delete();

        do_start();
        chk("start_busy", busy, 1);
        run_load("nominal", nom, 1'b0);

        do_start();
        chk("reload_done_drops", done, 0);
        run_load("stall", nom, 1'b1);

        do_start();
        run_load("zero_len", '{8'h00, 8'h00}, 1'b0);

        do_start();
        model(nom, oc, cnt);
        first4 = '{8'h00, 8'h03, 8'h01, 8'h31};
        send_bytes(first4, 1'b0, 100, nacc);
        @(negedge Clk);
        chk("midrst_write_seen", mem_we, 1);
        Reset = 1'b1;
        @(negedge Clk);
        chk("midrst_we", mem_we, 0);
        chk("midrst_ready", in_ready, 0);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_wdata", mem_wdata, 0);
        chk("midrst_done", done, 0);
        chk("midrst_count", count, 0);
        Reset = 1'b0;
        exp_wr.delete();
        do_start();
        run_load("after_rst", nom, 1'b0);

        do_start();
        model('{8'h00, 8'h01, 8'h02, 8'h55}, oc, cnt);
        chk("pin_rsv_outcome", oc, 1);
        send_bytes('{8'h00, 8'h01, 8'h02}, 1'b0, 100, nacc);
        check_end("reserved", oc, cnt);
        do_start();
        send_bytes('{8'h00, 8'h03}, 1'b0, 10, nacc);
        chk("err_ignores_bytes", nacc, 0);
        chk("err_sticky", err, 1);
        chk("err_no_done", done, 0);
        chk("err_count", count, 0);

        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk) Reset = 1'b0;
        chk("err_cleared", err, 0);
        do_start();
        run_load("oversize", '{8'h08, 8'h01}, 1'b0);

        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk) Reset = 1'b0;
        b = '{8'h08, 8'h00};
        for (int i = 0; i < 2048; i++) begin
            b.push_back(8'((i >> 8) & 1));
            b.push_back(8'(i & 8'hFF));
        end
        do_start();
        run_load("max_len", b, 1'b0);
        chk("max_last_addr", last_addr, 11'h7FF);
        chk("max_count", count, 2048);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
